// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: drives the imem request/response handshake,
// tags in-flight fetches with their PC and buffers returned words for ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_IF,
  input  logic        jmp_vld_IF,
  input  logic [31:0] jmp_addr_IF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc,
  output logic        IF_inst_vld
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(FIFO_DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] ptr_t;

  logic [31:0] fetch_pc;
  cnt_t        buf_cnt;
  cnt_t        outstanding;
  cnt_t        drop_cnt;
  ptr_t        buf_rd;
  ptr_t        buf_wr;
  ptr_t        tag_rd;
  ptr_t        tag_wr;
  logic [31:0] buf_pc   [FIFO_DEPTH];
  logic [31:0] buf_inst [FIFO_DEPTH];
  logic [31:0] tag_pc   [FIFO_DEPTH];

  logic        pop;
  logic        issue;
  logic        rsp;
  logic        push;
  logic [CW:0] occupancy;
  logic        unused_jmp_lsb;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FIFO_DEPTH - 1)) return '0;
    else                            return p + 1'b1;
  endfunction

  assign unused_jmp_lsb = ^jmp_addr_IF[1:0];

  assign pop       = IF_inst_vld & ~hold_IF & ~jmp_vld_IF;
  // Buffered plus in-flight words, counting the slot freed by this cycle's pop.
  assign occupancy = {1'b0, buf_cnt} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
  assign imem_req  = ~rst & ~jmp_vld_IF & (occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp       = imem_rvalid & (outstanding != '0);
  assign push      = rsp & (drop_cnt == '0) & ~jmp_vld_IF;

  assign IF_inst_vld = (buf_cnt != '0);
  assign IF_inst     = IF_inst_vld ? buf_inst[buf_rd] : '0;
  assign IF_pc       = IF_inst_vld ? buf_pc[buf_rd]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      buf_cnt     <= '0;
      buf_rd      <= '0;
      buf_wr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_wr   <= ptr_inc(tag_wr);
      end
      if (rsp) tag_rd <= ptr_inc(tag_rd);
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(rsp);
      if (jmp_vld_IF) begin
        // Everything still in flight belongs to the abandoned path.
        fetch_pc <= {jmp_addr_IF[31:2], 2'b00};
        buf_cnt  <= '0;
        buf_rd   <= '0;
        buf_wr   <= '0;
        drop_cnt <= outstanding - cnt_t'(rsp);
      end else begin
        buf_cnt <= buf_cnt + cnt_t'(push) - cnt_t'(pop);
        if (push) buf_wr <= ptr_inc(buf_wr);
        if (pop)  buf_rd <= ptr_inc(buf_rd);
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Tag and word storage carry no reset; validity comes from the counters.
  always_ff @(posedge clk) begin
    if (issue) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      buf_pc[buf_wr]   <= tag_pc[tag_rd];
      buf_inst[buf_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory model with random grant/latency and a
// program-order reference (sequential PCs from the latest redirect target).
module tb_if_fetch_stage;

  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_IF;
  logic        jmp_vld_IF;
  logic [31:0] jmp_addr_IF;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc;
  logic        IF_inst_vld;

  if_fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .hold_IF(hold_IF), .jmp_vld_IF(jmp_vld_IF),
    .jmp_addr_IF(jmp_addr_IF), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_inst(IF_inst), .IF_pc(IF_pc), .IF_inst_vld(IF_inst_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_req = 32'h0;
  logic        prev_jmp = 1'b0;
  logic        prev_hold_vld = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_inst = 32'h0;
  logic        spurious = 1'b0;
  logic        obs_vld, obs_req;
  logic [31:0] obs_pc, obs_inst, obs_addr;
  logic        seen_target;
  logic        reached;
  logic [31:0] a0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, let comb settle, check against the model.
  task automatic step(input logic h, input logic j, input logic [31:0] ja, input logic g);
    logic        rv;
    logic [31:0] rd;
    hold_IF = h; jmp_vld_IF = j; jmp_addr_IF = ja; imem_gnt = g;
    rv = 1'b0;
    rd = $urandom;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1;
      rd = inst_of(mq[0].addr);
      void'(mq.pop_front());
    end else if (spurious) begin
      rv = 1'b1;
    end
    spurious = 1'b0;
    imem_rvalid = rv; imem_rdata = rd;
    #1;
    obs_vld = IF_inst_vld; obs_pc = IF_pc; obs_inst = IF_inst;
    obs_req = imem_req; obs_addr = imem_addr;
    if (prev_jmp) check("vld_after_jump", {31'b0, obs_vld}, 32'd0);
    if (prev_hold_vld) begin
      check("hold_vld", {31'b0, obs_vld}, 32'd1);
      check("hold_pc", obs_pc, prev_pc);
      check("hold_inst", obs_inst, prev_inst);
    end
    if (j) check("req_during_jump", {31'b0, obs_req}, 32'd0);
    if (obs_req) check("imem_addr", obs_addr, exp_req);
    if (obs_req && g) begin
      mq.push_back('{obs_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_req += 32'd4;
      check("inflight_cap", {31'b0, mq.size() <= FIFO_DEPTH}, 32'd1);
    end
    if (obs_vld) check("inst_matches_pc", obs_inst, inst_of(obs_pc));
    if (obs_vld && !h && !j) begin
      check("consumed_pc", obs_pc, exp_pc);
      exp_pc += 32'd4;
    end
    if (j) begin
      exp_pc  = {ja[31:2], 2'b00};
      exp_req = {ja[31:2], 2'b00};
    end
    prev_jmp = j;
    prev_hold_vld = obs_vld & h & ~j;
    prev_pc = obs_pc;
    prev_inst = obs_inst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; hold_IF = 0; jmp_vld_IF = 0; jmp_addr_IF = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", {31'b0, IF_inst_vld}, 32'd0);
    check("rst_pc", IF_pc, 32'd0);
    check("rst_inst", IF_inst, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b0;

    // Back-to-back streaming into a hold at IF_pc=8
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1);
      check("stream_req", {31'b0, obs_req}, 32'd1);
      check("stream_addr", obs_addr, 32'(4 * k));
      if (k >= 2) begin
        check("stream_vld", {31'b0, obs_vld}, 32'd1);
        check("stream_pc", obs_pc, 32'(4 * (k - 2)));
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1);
      check("hold_head_pc", obs_pc, 32'h8);
      if (k > 0) check("hold_req_capped", {31'b0, obs_req}, 32'd0);
    end
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1);

    // Redirect with two stale requests in flight
    lat_min = 2; lat_max = 2;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      step(0, 0, 0, 1);
      if (mq.size() == 2) reached = 1'b1;
    end
    check("two_outstanding", {31'b0, reached}, 32'd1);
    step(0, 1, 32'h100, 1);
    seen_target = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 1);
      if (obs_vld && obs_pc == 32'h100) seen_target = 1'b1;
    end
    check("jump_target_seen", {31'b0, seen_target}, 32'd1);

    // Misaligned redirect together with hold
    lat_min = 1; lat_max = 1;
    step(1, 1, 32'h102, 1);
    step(0, 0, 0, 1);
    check("jmp_hold_addr", obs_addr, 32'h100);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1);

    // Grant withheld for four cycles
    a0 = 32'h0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      if (k == 0) a0 = obs_addr;
      else begin
        check("nognt_req", {31'b0, obs_req}, 32'd1);
        check("nognt_addr", obs_addr, a0);
      end
      if (k == 3) check("nognt_drained", {31'b0, obs_vld}, 32'd0);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1);

    // Randomised traffic
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 400; k++)
      step(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom, ($urandom % 10) < 7);

    // Reset mid-stream at IF_pc=0x20
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
    step(0, 1, 32'h0, 1);
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      step(0, 0, 0, 1);
      if (obs_vld && obs_pc == 32'h1C) reached = 1'b1;
    end
    check("reach_pc_1c", {31'b0, reached}, 32'd1);
    check("pre_rst_pc", IF_pc, 32'h20);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'b0, IF_inst_vld}, 32'd0);
    check("mid_rst_pc", IF_pc, 32'd0);
    check("mid_rst_inst", IF_inst, 32'd0);
    check("mid_rst_req", {31'b0, imem_req}, 32'd0);
    #1;
    rst = 1'b0;
    mq.delete();
    exp_pc = 32'h0; exp_req = 32'h0;
    prev_jmp = 1'b0; prev_hold_vld = 1'b0;
    spurious = 1'b1;
    step(0, 0, 0, 1);
    check("post_rst_req", {31'b0, obs_req}, 32'd1);
    check("post_rst_addr", obs_addr, 32'h0);
    for (int k = 1; k < 7; k++) begin
      step(0, 0, 0, 1);
      if (k >= 2) check("post_rst_pc", obs_pc, 32'(4 * (k - 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
